// File: rtl/mdu_scoreboard_pkg.sv
// Shared types and constants for the MDU scoreboard / writeback scheduler.
package mdu_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        SB_EMPTY,
        SB_PENDING,
        SB_HOLD
    } sb_state_t;

endpackage

// File: rtl/mdu_scoreboard_if.sv
// Decode, issue, MDU-result, pipeline-writeback and register-file signals of the scoreboard.
interface mdu_scoreboard_if #(
    parameter int XLEN = 32
) ();
    import mdu_scoreboard_pkg::*;

    logic                  de_valid;
    logic [REG_ADDR_W-1:0] de_rs1;
    logic [REG_ADDR_W-1:0] de_rs2;
    logic [REG_ADDR_W-1:0] de_rd;
    logic                  sb_stall;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;

    logic                  mdu_done_valid;
    logic [REG_ADDR_W-1:0] mdu_done_rd;
    logic [XLEN-1:0]       mdu_done_data;
    logic                  mdu_done_ready;

    logic                  pipe_wb_valid;
    logic [REG_ADDR_W-1:0] pipe_wb_rd;
    logic [XLEN-1:0]       pipe_wb_data;
    logic                  wb_hold;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;

    modport master (
        output de_valid, de_rs1, de_rs2, de_rd,
        output iss_valid, iss_rd,
        output mdu_done_valid, mdu_done_rd, mdu_done_data,
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  sb_stall, mdu_done_ready, wb_hold, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_rd,
        input  iss_valid, iss_rd,
        input  mdu_done_valid, mdu_done_rd, mdu_done_data,
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output sb_stall, mdu_done_ready, wb_hold, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/mdu_scoreboard.sv
// MDU scoreboard: busy-bit hazard stall plus a one-entry result buffer that
// shares the register-file write port with the pipeline, forcing a slot after starvation.
module mdu_scoreboard
    import mdu_scoreboard_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    mdu_scoreboard_if.slave sb
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    sb_state_t             r_state;
    sb_state_t             w_state_nxt;
    logic [3:0]            r_starve;
    logic [3:0]            w_starve_nxt;
    logic [3:0]            w_starve_inc;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic [REG_ADDR_W-1:0] r_hold_rd;
    logic [XLEN-1:0]       r_hold_data;
    logic                  r_wb_hold;
    logic                  w_accept;
    logic                  w_mdu_wr;

    assign w_starve_inc = r_starve + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        w_accept     = 1'b0;
        w_mdu_wr     = 1'b0;
        unique case (r_state)
            SB_EMPTY: begin
                if (sb.mdu_done_valid) begin
                    w_accept     = 1'b1;
                    w_starve_nxt = '0;
                    w_state_nxt  = SB_PENDING;
                end
            end
            SB_PENDING, SB_HOLD: begin
                // x0 results are dropped silently; otherwise write only when the pipeline leaves the port idle
                if (r_hold_rd == '0) begin
                    w_state_nxt = SB_EMPTY;
                end else if (!sb.pipe_wb_valid) begin
                    w_mdu_wr    = 1'b1;
                    w_state_nxt = SB_EMPTY;
                end else if (r_state == SB_PENDING) begin
                    w_starve_nxt = w_starve_inc;
                    if (w_starve_inc >= LIMIT) begin
                        w_state_nxt = SB_HOLD;
                    end
                end
            end
            default: w_state_nxt = SB_EMPTY;
        endcase
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_mdu_wr) begin
            w_busy_nxt[r_hold_rd] = 1'b0;
        end
        if (sb.iss_valid && (sb.iss_rd != '0)) begin
            w_busy_nxt[sb.iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SB_EMPTY;
            r_starve    <= '0;
            r_busy      <= '0;
            r_hold_rd   <= '0;
            r_hold_data <= '0;
            r_wb_hold   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_starve  <= w_starve_nxt;
            r_busy    <= w_busy_nxt;
            r_wb_hold <= (w_state_nxt == SB_HOLD);
            if (w_accept) begin
                r_hold_rd   <= sb.mdu_done_rd;
                r_hold_data <= sb.mdu_done_data;
            end
        end
    end

    // Stall reads the registered busy vector only: one extra stall cycle after writeback
    assign sb.sb_stall = !reset && sb.de_valid &&
                         (r_busy[sb.de_rs1] || r_busy[sb.de_rs2] || r_busy[sb.de_rd]);

    assign sb.mdu_done_ready = reset || (r_state == SB_EMPTY);
    assign sb.wb_hold        = r_wb_hold;

    assign sb.rf_we    = !reset && (sb.pipe_wb_valid || w_mdu_wr);
    assign sb.rf_waddr = sb.pipe_wb_valid ? sb.pipe_wb_rd   : r_hold_rd;
    assign sb.rf_wdata = sb.pipe_wb_valid ? sb.pipe_wb_data : r_hold_data;

endmodule

// File: tb/tb_mdu_scoreboard.sv
// Directed self-checking bench for mdu_scoreboard (XLEN=32, STARVE_LIMIT=4).
module tb_mdu_scoreboard;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mdu_scoreboard_if #(.XLEN(32)) sbif ();

    mdu_scoreboard #(
        .XLEN        (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol properties the pipeline/decode side must never violate
    always @(negedge clk) begin
        if (!reset) begin
            if (sbif.pipe_wb_valid && sbif.wb_hold) begin
                errors++;
                $display("FAIL protocol_hold: pipe_wb_valid=1 while wb_hold=1 (required 0)");
            end
            if (sbif.iss_valid && sbif.iss_rd != 5'd0 && sbif.rf_we && !sbif.pipe_wb_valid &&
                sbif.rf_waddr == sbif.iss_rd) begin
                errors++;
                $display("FAIL protocol_iss: issue to rd=%0d in its MDU writeback cycle", sbif.iss_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sbif.de_valid       = 1'b0;
        sbif.de_rs1         = 5'd0;
        sbif.de_rs2         = 5'd0;
        sbif.de_rd          = 5'd0;
        sbif.iss_valid      = 1'b0;
        sbif.iss_rd         = 5'd0;
        sbif.mdu_done_valid = 1'b0;
        sbif.mdu_done_rd    = 5'd0;
        sbif.mdu_done_data  = 32'd0;
        sbif.pipe_wb_valid  = 1'b0;
        sbif.pipe_wb_rd     = 5'd0;
        sbif.pipe_wb_data   = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        sbif.pipe_wb_valid = 1'b1;
        sbif.pipe_wb_rd    = 5'd3;
        sbif.de_valid      = 1'b1;
        sbif.de_rs1        = 5'd5;
        #2;
        checks++;
        if ({sbif.sb_stall, sbif.rf_we, sbif.mdu_done_ready, sbif.wb_hold} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_during: stall/we/ready/hold=%b required 0010",
                     {sbif.sb_stall, sbif.rf_we, sbif.mdu_done_ready, sbif.wb_hold});
        end
        tick();
        reset = 1'b0;
        idle();
        tick();
        checks++;
        if ({sbif.sb_stall, sbif.rf_we, sbif.mdu_done_ready, sbif.wb_hold} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_after: stall/we/ready/hold=%b required 0010",
                     {sbif.sb_stall, sbif.rf_we, sbif.mdu_done_ready, sbif.wb_hold});
        end
    endtask

    task automatic test_raw();
        sbif.iss_valid = 1'b1;
        sbif.iss_rd    = 5'd5;
        tick();
        idle();
        sbif.de_valid = 1'b1;
        sbif.de_rs1   = 5'd5;
        #2;
        checks++;
        if (sbif.sb_stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall: sb_stall=%b required 1", sbif.sb_stall);
        end
        tick();
        sbif.mdu_done_valid = 1'b1;
        sbif.mdu_done_rd    = 5'd5;
        sbif.mdu_done_data  = 32'h0000_1234;
        #2;
        checks++;
        if ({sbif.mdu_done_ready, sbif.rf_we, sbif.sb_stall} !== 3'b101) begin
            errors++;
            $display("FAIL raw_accept: ready/we/stall=%b required 101",
                     {sbif.mdu_done_ready, sbif.rf_we, sbif.sb_stall});
        end
        tick();
        sbif.mdu_done_valid = 1'b0;
        #2;
        checks++;
        if ({sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata, sbif.sb_stall} !== {1'b1, 5'd5, 32'h0000_1234, 1'b1}) begin
            errors++;
            $display("FAIL raw_write: we=%b addr=%0d data=%h stall=%b required 1 5 00001234 1",
                     sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata, sbif.sb_stall);
        end
        tick();
        #2;
        checks++;
        if ({sbif.sb_stall, sbif.rf_we} !== 2'b00) begin
            errors++;
            $display("FAIL raw_release: stall/we=%b required 00", {sbif.sb_stall, sbif.rf_we});
        end
        idle();
    endtask

    task automatic test_starve();
        sbif.iss_valid = 1'b1;
        sbif.iss_rd    = 5'd7;
        tick();
        idle();
        sbif.pipe_wb_valid  = 1'b1;
        sbif.pipe_wb_rd     = 5'd10;
        sbif.pipe_wb_data   = 32'h0000_AAAA;
        sbif.mdu_done_valid = 1'b1;
        sbif.mdu_done_rd    = 5'd7;
        sbif.mdu_done_data  = 32'h0000_0077;
        tick();
        sbif.mdu_done_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sbif.de_valid = 1'b1;
            sbif.de_rs1   = 5'd7;
            #2;
            checks++;
            if ({sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata, sbif.wb_hold, sbif.mdu_done_ready, sbif.sb_stall}
                !== {1'b1, 5'd10, 32'h0000_AAAA, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL starve_pipe%0d: we=%b addr=%0d data=%h hold=%b ready=%b stall=%b required 1 10 0000aaaa 0 0 1",
                         k, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata, sbif.wb_hold,
                         sbif.mdu_done_ready, sbif.sb_stall);
            end
            tick();
        end
        sbif.pipe_wb_valid = sbif.wb_hold ? 1'b0 : 1'b1;
        #2;
        checks++;
        if ({sbif.wb_hold, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata} !== {1'b1, 1'b1, 5'd7, 32'h0000_0077}) begin
            errors++;
            $display("FAIL starve_hold: hold=%b we=%b addr=%0d data=%h required 1 1 7 00000077",
                     sbif.wb_hold, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata);
        end
        sbif.pipe_wb_valid = 1'b0;
        tick();
        #2;
        checks++;
        if ({sbif.wb_hold, sbif.rf_we, sbif.mdu_done_ready, sbif.sb_stall} !== 4'b0010) begin
            errors++;
            $display("FAIL starve_after: hold/we/ready/stall=%b required 0010",
                     {sbif.wb_hold, sbif.rf_we, sbif.mdu_done_ready, sbif.sb_stall});
        end
        idle();
    endtask

    task automatic test_back_to_back();
        sbif.mdu_done_valid = 1'b1;
        sbif.mdu_done_rd    = 5'd3;
        sbif.mdu_done_data  = 32'h0000_0033;
        #2;
        checks++;
        if (sbif.mdu_done_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: ready=%b required 1", sbif.mdu_done_ready);
        end
        tick();
        sbif.mdu_done_rd   = 5'd4;
        sbif.mdu_done_data = 32'h0000_0044;
        #2;
        checks++;
        if ({sbif.mdu_done_ready, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata} !== {1'b0, 1'b1, 5'd3, 32'h0000_0033}) begin
            errors++;
            $display("FAIL b2b_write3: ready=%b we=%b addr=%0d data=%h required 0 1 3 00000033",
                     sbif.mdu_done_ready, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata);
        end
        tick();
        #2;
        checks++;
        if ({sbif.mdu_done_ready, sbif.rf_we} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept4: ready/we=%b required 10", {sbif.mdu_done_ready, sbif.rf_we});
        end
        tick();
        sbif.mdu_done_valid = 1'b0;
        #2;
        checks++;
        if ({sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata} !== {1'b1, 5'd4, 32'h0000_0044}) begin
            errors++;
            $display("FAIL b2b_write4: we=%b addr=%0d data=%h required 1 4 00000044",
                     sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata);
        end
        tick();
        idle();
    endtask

    task automatic test_waw_x0();
        sbif.iss_valid = 1'b1;
        sbif.iss_rd    = 5'd9;
        tick();
        idle();
        sbif.de_valid = 1'b1;
        sbif.de_rs1   = 5'd1;
        sbif.de_rs2   = 5'd2;
        sbif.de_rd    = 5'd9;
        #2;
        checks++;
        if (sbif.sb_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_stall: sb_stall=%b required 1", sbif.sb_stall);
        end
        sbif.de_rd = 5'd8;
        #1;
        checks++;
        if (sbif.sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL waw_other_rd: sb_stall=%b required 0", sbif.sb_stall);
        end
        idle();
        sbif.iss_valid = 1'b1;
        sbif.iss_rd    = 5'd0;
        tick();
        idle();
        sbif.de_valid = 1'b1;
        #2;
        checks++;
        if (sbif.sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: sb_stall=%b required 0", sbif.sb_stall);
        end
        idle();
        sbif.mdu_done_valid = 1'b1;
        sbif.mdu_done_rd    = 5'd0;
        sbif.mdu_done_data  = 32'hDEAD_BEEF;
        tick();
        sbif.mdu_done_valid = 1'b0;
        #2;
        checks++;
        if ({sbif.rf_we, sbif.mdu_done_ready} !== 2'b00) begin
            errors++;
            $display("FAIL x0_drop: we/ready=%b required 00", {sbif.rf_we, sbif.mdu_done_ready});
        end
        tick();
        sbif.pipe_wb_valid = 1'b1;
        sbif.pipe_wb_rd    = 5'd0;
        sbif.pipe_wb_data  = 32'h0000_5555;
        #2;
        checks++;
        if ({sbif.mdu_done_ready, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata} !== {1'b1, 1'b1, 5'd0, 32'h0000_5555}) begin
            errors++;
            $display("FAIL x0_pipe: ready=%b we=%b addr=%0d data=%h required 1 1 0 00005555",
                     sbif.mdu_done_ready, sbif.rf_we, sbif.rf_waddr, sbif.rf_wdata);
        end
        tick();
        idle();
        sbif.mdu_done_valid = 1'b1;
        sbif.mdu_done_rd    = 5'd9;
        tick();
        idle();
        tick();
        sbif.de_valid = 1'b1;
        sbif.de_rd    = 5'd9;
        #2;
        checks++;
        if (sbif.sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL waw_cleared: sb_stall=%b required 0", sbif.sb_stall);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        sbif.iss_valid = 1'b1;
        sbif.iss_rd    = 5'd12;
        tick();
        idle();
        sbif.mdu_done_valid = 1'b1;
        sbif.mdu_done_rd    = 5'd12;
        sbif.mdu_done_data  = 32'h0000_0C0C;
        tick();
        idle();
        reset         = 1'b1;
        sbif.de_valid = 1'b1;
        sbif.de_rs1   = 5'd12;
        #2;
        checks++;
        if ({sbif.rf_we, sbif.mdu_done_ready, sbif.sb_stall} !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_during: we/ready/stall=%b required 010",
                     {sbif.rf_we, sbif.mdu_done_ready, sbif.sb_stall});
        end
        tick();
        reset = 1'b0;
        #2;
        checks++;
        if ({sbif.rf_we, sbif.mdu_done_ready, sbif.sb_stall, sbif.wb_hold} !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_after: we/ready/stall/hold=%b required 0100",
                     {sbif.rf_we, sbif.mdu_done_ready, sbif.sb_stall, sbif.wb_hold});
        end
        tick();
        #2;
        checks++;
        if ({sbif.rf_we, sbif.sb_stall} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_settled: we/stall=%b required 00", {sbif.rf_we, sbif.sb_stall});
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_starve();
        test_back_to_back();
        test_waw_x0();
        test_reset_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
